// File: rtl/seg14_msg_scroller.sv
// Message buffer and 14-segment character generator for the 12-digit display scanner.
// Build option SEG14_SCROLL_EN compiles in left-scrolling of messages longer than 12 characters.
module seg14_msg_scroller #(
  parameter int MSG_DEPTH  = 32,
  parameter int SCROLL_DIV = 12000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [5:0]  wr_char,
  input  logic        wr_last,
  input  logic        digit_req,
  input  logic [3:0]  digit_idx,
  output logic        seg_valid,
  output logic [13:0] segm,
  output logic [5:0]  msg_len,
  output logic        busy
);
  // state  | meaning
  // SHOW   | committed message on display, waiting for the first beat of a new one
  // LOAD   | receiving beats of a new message, display blanked
  // COMMIT | one cycle publishing the new length, no beat accepted
  typedef enum logic [1:0] {SHOW, LOAD, COMMIT} state_t;

  localparam int         AW     = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1;
  localparam logic [5:0] DEPTH6 = 6'(MSG_DEPTH);

  state_t      r_state;
  logic [5:0]  r_cnt;
  logic [5:0]  r_msg_len;
  logic        r_busy;
  logic        r_wr_ready;
  logic [5:0]  r_buf [MSG_DEPTH];
  logic [13:0] r_segm;
  logic        r_seg_valid;

  logic        w_acc;
  logic [5:0]  w_wptr;
  logic        w_wr_en;
  logic [5:0]  w_cnt_nxt;
  logic [5:0]  w_offset;
  logic [6:0]  w_sum;
  logic [6:0]  w_wrap;
  logic        w_blank;
  logic [5:0]  w_char;

  function automatic logic [13:0] f_glyph(input logic [5:0] c);
    logic [13:0] g;
    g = 14'd0;
    case (c)
      6'd1:  g = 14'b1110111_1000000;
      6'd2:  g = 14'b1111000_1010010;
      6'd3:  g = 14'b1001110_0000000;
      6'd4:  g = 14'b1111000_0010010;
      6'd5:  g = 14'b1001111_0000000;
      6'd6:  g = 14'b1000111_0000000;
      6'd7:  g = 14'b1011110_1000000;
      6'd8:  g = 14'b0110111_1000000;
      6'd9:  g = 14'b1001000_0010010;
      6'd10: g = 14'b0111100_0000000;
      6'd11: g = 14'b0000111_0001100;
      6'd12: g = 14'b0001110_0000000;
      6'd13: g = 14'b0110110_0101000;
      6'd14: g = 14'b0110110_0100100;
      6'd15: g = 14'b1110110_0100100;
      6'd16: g = 14'b1111110_0000000;
      6'd17: g = 14'b1100111_1000000;
      6'd18: g = 14'b1111110_0000100;
      6'd19: g = 14'b1100111_1000100;
      6'd20: g = 14'b1011011_1000000;
      6'd21: g = 14'b1000000_0010010;
      6'd22: g = 14'b0111110_0000000;
      6'd23: g = 14'b0000110_0001001;
      6'd24: g = 14'b0110110_0000101;
      6'd25: g = 14'b0000000_0101101;
      6'd26: g = 14'b0000000_0101010;
      6'd27: g = 14'b1001000_0001001;
      6'd28: g = 14'b1111110_0001001;
      6'd29: g = 14'b0110000_0001000;
      6'd30: g = 14'b1101101_1000000;
      6'd31: g = 14'b1111000_1000000;
      6'd32: g = 14'b0110011_1000000;
      6'd33: g = 14'b1001011_0000100;
      6'd34: g = 14'b1011111_1000000;
      6'd35: g = 14'b1110000_0000000;
      6'd36: g = 14'b1111111_1000000;
      6'd37: g = 14'b1111011_1000000;
      default: g = 14'd0;
    endcase
    return g;
  endfunction

  assign w_acc     = wr_valid && r_wr_ready;
  // The first beat of a message always lands at address 0, whatever count is left over.
  assign w_wptr    = (r_state == LOAD) ? r_cnt : 6'd0;
  assign w_wr_en   = w_acc && (w_wptr < DEPTH6);
  assign w_cnt_nxt = w_wr_en ? w_wptr + 6'd1 : w_wptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= SHOW;
      r_cnt      <= 6'd0;
      r_msg_len  <= 6'd0;
      r_busy     <= 1'b0;
      r_wr_ready <= 1'b1;
    end else begin
      case (r_state)
        SHOW, LOAD: begin
          if (w_acc) begin
            r_cnt      <= w_cnt_nxt;
            r_state    <= wr_last ? COMMIT : LOAD;
            r_busy     <= 1'b1;
            r_wr_ready <= !wr_last;
          end
        end
        COMMIT: begin
          r_msg_len  <= r_cnt;
          r_state    <= SHOW;
          r_busy     <= 1'b0;
          r_wr_ready <= 1'b1;
        end
        default: begin
          r_state    <= SHOW;
          r_busy     <= 1'b0;
          r_wr_ready <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_buf[AW'(w_wptr)] <= wr_char;
  end

`ifdef SEG14_SCROLL_EN
  localparam int PW = $clog2(SCROLL_DIV);

  logic [PW-1:0] r_presc;
  logic [5:0]    r_offset;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc  <= '0;
      r_offset <= 6'd0;
    end else if (r_state == COMMIT || r_msg_len <= 6'd12) begin
      r_presc  <= '0;
      r_offset <= 6'd0;
    end else if (r_presc == PW'(SCROLL_DIV - 1)) begin
      r_presc  <= '0;
      r_offset <= (r_offset + 6'd1 == r_msg_len) ? 6'd0 : r_offset + 6'd1;
    end else begin
      r_presc  <= r_presc + 1'b1;
    end
  end

  assign w_offset = r_offset;
`else
  wire w_unused_div = ^32'(SCROLL_DIV);
  assign w_offset = 6'd0;
`endif

  // offset < len and idx < len, so one conditional subtract is a full modulo.
  assign w_sum   = {1'b0, w_offset} + {3'b000, digit_idx};
  assign w_wrap  = (w_sum >= {1'b0, r_msg_len}) ? w_sum - {1'b0, r_msg_len} : w_sum;
  assign w_blank = r_busy || (digit_idx > 4'd11) || ({2'b00, digit_idx} >= r_msg_len);
  assign w_char  = r_buf[AW'(w_wrap)];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_segm      <= 14'd0;
      r_seg_valid <= 1'b0;
    end else begin
      r_seg_valid <= digit_req;
      if (digit_req) r_segm <= w_blank ? 14'd0 : f_glyph(w_char);
    end
  end

  assign wr_ready  = r_wr_ready;
  assign busy      = r_busy;
  assign msg_len   = r_msg_len;
  assign segm      = r_segm;
  assign seg_valid = r_seg_valid;
endmodule

// File: tb/tb_seg14_msg_scroller.sv
// Randomized bench for seg14_msg_scroller against a message/offset reference model.
module tb_seg14_msg_scroller;
  localparam int DIV   = 4;
  localparam int DEPTH = 32;

  localparam logic [13:0] FONT [0:37] = '{
    14'b0000000_0000000, 14'b1110111_1000000, 14'b1111000_1010010, 14'b1001110_0000000,
    14'b1111000_0010010, 14'b1001111_0000000, 14'b1000111_0000000, 14'b1011110_1000000,
    14'b0110111_1000000, 14'b1001000_0010010, 14'b0111100_0000000, 14'b0000111_0001100,
    14'b0001110_0000000, 14'b0110110_0101000, 14'b0110110_0100100, 14'b1110110_0100100,
    14'b1111110_0000000, 14'b1100111_1000000, 14'b1111110_0000100, 14'b1100111_1000100,
    14'b1011011_1000000, 14'b1000000_0010010, 14'b0111110_0000000, 14'b0000110_0001001,
    14'b0110110_0000101, 14'b0000000_0101101, 14'b0000000_0101010, 14'b1001000_0001001,
    14'b1111110_0001001, 14'b0110000_0001000, 14'b1101101_1000000, 14'b1111000_1000000,
    14'b0110011_1000000, 14'b1001011_0000100, 14'b1011111_1000000, 14'b1110000_0000000,
    14'b1111111_1000000, 14'b1111011_1000000
  };

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [5:0]  wr_char = 6'd0;
  logic        wr_last = 1'b0;
  logic        digit_req = 1'b0;
  logic [3:0]  digit_idx = 4'd0;
  logic        seg_valid;
  logic [13:0] segm;
  logic [5:0]  msg_len;
  logic        busy;

  seg14_msg_scroller #(.MSG_DEPTH(DEPTH), .SCROLL_DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_char(wr_char), .wr_last(wr_last),
    .digit_req(digit_req), .digit_idx(digit_idx),
    .seg_valid(seg_valid), .segm(segm), .msg_len(msg_len), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int mbuf [DEPTH];
  int mlen = 0;
  int commit_edge = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [13:0] glyph(input int c);
    return (c < 38) ? FONT[c] : 14'd0;
  endfunction

  // Character shown at digit idx for a request sampled at edge r.
  function automatic logic [13:0] model_seg(input int idx, input int r);
    int off;
    if (mlen == 0 || idx > 11) return 14'd0;
`ifdef SEG14_SCROLL_EN
    if (mlen > 12) begin
      off = ((r - commit_edge - 1) / DIV) % mlen;
      return glyph(mbuf[(off + idx) % mlen]);
    end
`endif
    if (idx >= mlen) return 14'd0;
    return glyph(mbuf[idx]);
  endfunction

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic do_read(input int idx);
    logic [13:0] e;
    digit_req = 1'b1;
    digit_idx = 4'(idx);
    step();
    e = model_seg(idx, cyc);
    chk("seg_valid", 32'(seg_valid), 1);
    chk($sformatf("segm idx%0d", idx), 32'(segm), 32'(e));
    digit_req = 1'b0;
    step();
    chk("seg_valid_idle", 32'(seg_valid), 0);
    chk("segm_hold", 32'(segm), 32'(e));
  endtask

  task automatic send_msg(input int codes[$], input bit gaps, input bit commit_read);
    int n;
    n = codes.size();
    for (int k = 0; k < n; k++) begin
      if (gaps) begin
        wr_valid = 1'b0;
        repeat ($urandom_range(0, 2)) step();
      end
      wr_valid = 1'b1;
      wr_char  = 6'(codes[k]);
      wr_last  = (k == n - 1);
      chk("wr_ready_beat", 32'(wr_ready), 1);
      step();
      if (k < DEPTH) mbuf[k] = codes[k];
      chk("busy_beat", 32'(busy), 1);
    end
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    chk("wr_ready_commit", 32'(wr_ready), 0);
    mlen = (n > DEPTH) ? DEPTH : n;
    commit_edge = cyc + 1;
    if (commit_read) begin
      digit_req = 1'b1;
      digit_idx = 4'd0;
      step();
      chk("segm_commit_cycle", 32'(segm), 0);
      chk("seg_valid_commit", 32'(seg_valid), 1);
      step();
      chk("segm_after_commit", 32'(segm), 32'(model_seg(0, cyc)));
      digit_req = 1'b0;
    end else begin
      step();
    end
    chk("busy_done", 32'(busy), 0);
    chk("msg_len", 32'(msg_len), mlen);
  endtask

  initial begin
    int q[$];
    int n;

    repeat (3) step();
    chk("rst_segm", 32'(segm), 0);
    chk("rst_seg_valid", 32'(seg_valid), 0);
    chk("rst_wr_ready", 32'(wr_ready), 1);
    chk("rst_msg_len", 32'(msg_len), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 12; i++) do_read(i);

    q = '{14, 1, 4, 1};
    send_msg(q, 1'b0, 1'b0);
    do_read(0); do_read(1); do_read(2); do_read(3); do_read(4); do_read(11);

    q.delete();
    for (int k = 1; k <= 14; k++) q.push_back(k);
    send_msg(q, 1'b0, 1'b0);
    do_read(11);
    while (cyc < commit_edge + 12) step();
    do_read(11);
    for (int j = 0; j < 24; j++) begin
      if ($urandom_range(0, 1) == 1) step();
      do_read($urandom_range(0, 15));
    end

    q.delete();
    for (int k = 0; k < 40; k++) q.push_back($urandom_range(0, 63));
    send_msg(q, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) do_read(i);

    for (int k = 0; k < 3; k++) begin
      wr_valid = 1'b1;
      wr_char  = 6'($urandom_range(1, 37));
      wr_last  = 1'b0;
      step();
      mbuf[k] = int'(wr_char);
    end
    wr_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    mlen = 0;
    chk("midload_rst_msg_len", 32'(msg_len), 0);
    chk("midload_rst_busy", 32'(busy), 0);
    chk("midload_rst_wr_ready", 32'(wr_ready), 1);
    step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 12; i++) do_read(i);

    for (int m = 0; m < 10; m++) begin
      q.delete();
      n = $urandom_range(1, 40);
      for (int k = 0; k < n; k++) q.push_back($urandom_range(0, 63));
      send_msg(q, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      for (int j = 0; j < 14; j++) begin
        if ($urandom_range(0, 2) == 0) step();
        do_read($urandom_range(0, 15));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
